// File: rtl/swarm_pkg.sv
// swarm_pkg: shared register-bus types and constants
package swarm_pkg;
   localparam int ID_LAST = 8;
   localparam int ID_W = $clog2(ID_LAST);
   typedef logic [31:0] reg_data_t;
   localparam reg_data_t REG_BUS_ERR_DATA = 32'hDEAD_BEEF;
   localparam int REG_BUS_TIMEOUT = 1024;
   typedef enum logic [2:0] {
      ARB_IDLE      = 3'd0,
      ARB_WRITE     = 3'd1,
      ARB_READ_REQ  = 3'd2,
      ARB_READ_WAIT = 3'd3,
      ARB_RESP      = 3'd4
   } regbus_arb_state_t;
endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, lowest index at or above ptr wins
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] j;
   // scan from the farthest offset down so the nearest requester at/after ptr overwrites
   always_comb begin
      gnt = '0;
      idx = '0;
      j   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % N);
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
            idx    = j;
         end
      end
   end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sharing of the component register bus with read timeout
module reg_bus_arbiter
   import swarm_pkg::*;
#(
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = REG_BUS_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0]              req_write,
   input  logic [N_REQ-1:0][15:0]        req_addr,
   input  logic [N_REQ-1:0][31:0]        req_wdata,
   output logic [N_REQ-1:0]              req_ready,
   output logic [N_REQ-1:0]              resp_valid,
   input  logic [N_REQ-1:0]              resp_ready,
   output logic [31:0]                   resp_data,
   output logic                          resp_err,
   output logic [ID_LAST-1:0]            reg_bus_wvalid,
   output logic [15:0]                   reg_bus_waddr,
   output logic [31:0]                   reg_bus_wdata,
   output logic [ID_LAST-1:0]            reg_bus_arvalid,
   output logic [15:0]                   reg_bus_araddr,
   input  logic [ID_LAST-1:0]            reg_bus_rvalid,
   input  reg_data_t [ID_LAST-1:0]       reg_bus_rdata
);
   localparam int IW = $clog2(N_REQ);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [2:0] ST_IDLE      = ARB_IDLE;
   localparam logic [2:0] ST_WRITE     = ARB_WRITE;
   localparam logic [2:0] ST_READ_REQ  = ARB_READ_REQ;
   localparam logic [2:0] ST_READ_WAIT = ARB_READ_WAIT;
   localparam logic [2:0] ST_RESP      = ARB_RESP;

   logic [2:0]      state;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   g_q;
   logic [ID_W-1:0] id_q;
   logic [7:0]      off_q;
   logic [31:0]     wdata_q;
   logic [31:0]     data_q;
   logic            err_q;
   logic [CW-1:0]   cnt;
   logic [N_REQ-1:0] gnt;
   logic [IW-1:0]   pick;
   logic [15:0]     pick_addr;
   logic            pick_bad;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (pick)
   );

   // address of the candidate winner and whether its component ID exists
   always_comb begin
      pick_addr = req_addr[pick];
      pick_bad  = int'(pick_addr[15:8]) >= ID_LAST;
   end

   // transaction FSM: grant, strobe, wait for read data or timeout, hold response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         g_q     <= '0;
         id_q    <= '0;
         off_q   <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: if (|req_valid) begin
               g_q     <= pick;
               id_q    <= pick_addr[8 +: ID_W];
               off_q   <= pick_addr[7:0];
               wdata_q <= req_wdata[pick];
               err_q   <= pick_bad;
               data_q  <= pick_bad ? REG_BUS_ERR_DATA : 32'h0;
               state   <= pick_bad ? ST_RESP : (req_write[pick] ? ST_WRITE : ST_READ_REQ);
            end
            ST_WRITE: state <= ST_RESP;
            ST_READ_REQ: begin
               cnt   <= '0;
               state <= ST_READ_WAIT;
            end
            ST_READ_WAIT: if (reg_bus_rvalid[id_q]) begin
               data_q <= reg_bus_rdata[id_q];
               err_q  <= 1'b0;
               state  <= ST_RESP;
            end else if (int'(cnt) == TIMEOUT_CYCLES - 1) begin
               data_q <= REG_BUS_ERR_DATA;
               err_q  <= 1'b1;
               state  <= ST_RESP;
            end else begin
               cnt <= cnt + 1'b1;
            end
            ST_RESP: if (resp_ready[g_q]) begin
               state  <= ST_IDLE;
               rr_ptr <= (int'(g_q) == N_REQ - 1) ? '0 : g_q + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // strobes and responses decoded from state and latched request; grant is masked during reset
   always_comb begin
      req_ready       = (state == ST_IDLE && !rst) ? gnt : '0;
      resp_valid      = (state == ST_RESP) ? (N_REQ'(1) << g_q) : '0;
      resp_data       = (state == ST_RESP) ? data_q : '0;
      resp_err        = (state == ST_RESP) && err_q;
      reg_bus_wvalid  = (state == ST_WRITE) ? (ID_LAST'(1) << id_q) : '0;
      reg_bus_arvalid = (state == ST_READ_REQ) ? (ID_LAST'(1) << id_q) : '0;
      reg_bus_waddr   = {8'b0, off_q};
      reg_bus_araddr  = {8'b0, off_q};
      reg_bus_wdata   = wdata_q;
   end
endmodule
